// File: rtl/keypad_entry.sv
// 4x4 keypad scanner: column rotation, 2-flop row synchronizer, per-scan classification,
// scan-rate debounce FSM and a four-digit entry shift register.
module keypad_entry #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_REL} state_t;

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       acc_n_q, acc_n_d;
  logic [3:0]       acc_code_q, acc_code_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;

  logic             last, scan_done, accept;
  logic [3:0]       hits, cur_code, scan_code;
  logic [2:0]       hit_pc, sum;
  logic [1:0]       hit_row, col_hits, total;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h4;  4'h2: key_map = 4'h7;  4'h3: key_map = 4'h0;
      4'h4: key_map = 4'h2;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h8;  4'h7: key_map = 4'hF;
      4'h8: key_map = 4'h3;  4'h9: key_map = 4'h6;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hE;
      4'hC: key_map = 4'hA;  4'hD: key_map = 4'hB;  4'hE: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  always_comb begin
    sync1_d    = row;
    sync2_d    = sync1_q;
    last       = (div_q == DIV_LAST);
    div_d      = last ? '0 : div_q + DIV_W'(1);
    col_idx_d  = last ? col_idx_q + 2'd1 : col_idx_q;
    col_d      = last ? {col_q[2:0], col_q[3]} : col_q;

    hits    = ~sync2_q;
    hit_pc  = '0;
    hit_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (hits[i]) begin
        hit_pc  = hit_pc + 3'd1;
        hit_row = 2'(i);
      end
    end
    // Per-scan key count saturates at 2: anything beyond one key is MULTI anyway.
    col_hits  = (hit_pc > 3'd1) ? 2'd2 : hit_pc[1:0];
    sum       = {1'b0, acc_n_q} + {1'b0, col_hits};
    total     = (sum > 3'd2) ? 2'd2 : sum[1:0];
    cur_code  = key_map(col_idx_q, hit_row);
    scan_code = (acc_n_q == 2'd0) ? cur_code : acc_code_q;
    scan_done = last && (col_idx_q == 2'd3);

    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (last) begin
      acc_n_d    = scan_done ? 2'd0 : total;
      acc_code_d = scan_done ? 4'h0 : scan_code;
    end

    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    accept      = 1'b0;
    if (scan_done) begin
      case (state_q)
        S_IDLE: if (total == 2'd1) begin
          cand_d = scan_code;
          if (DEBOUNCE <= 1) begin
            accept  = 1'b1;
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else begin
            state_d = S_CAND;
            cnt_d   = CNT_W'(1);
          end
        end
        S_CAND: if (total == 2'd1 && scan_code == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) begin
            accept  = 1'b1;
            state_d = S_PRESSED;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        S_PRESSED: if (total == 2'd0) begin
          state_d = (DEBOUNCE <= 1) ? S_IDLE : S_REL;
          cnt_d   = (DEBOUNCE <= 1) ? '0 : CNT_W'(1);
        end
        default: if (total == 2'd0) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end
      endcase
    end

    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    dig1_d      = accept ? cand_d : dig1_q;
    dig2_d      = accept ? dig1_q : dig2_q;
    dig3_d      = accept ? dig2_q : dig3_q;
    dig4_d      = accept ? dig3_q : dig4_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      div_q       <= '0;
      col_idx_q   <= '0;
      col_q       <= 4'b1110;
      acc_n_q     <= '0;
      acc_code_q  <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      dig1_q      <= '0;
      dig2_q      <= '0;
      dig3_q      <= '0;
      dig4_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      dig1_q      <= dig1_d;
      dig2_q      <= dig2_d;
      dig3_q      <= dig3_d;
      dig4_q      <= dig4_d;
    end
  end

  assign col       = col_q;
  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign dig3      = dig3_q;
  assign dig4      = dig4_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = (state_q == S_PRESSED) || (state_q == S_REL);

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100000, clk cycles each column is driven (1 ms at 100 MHz); minimum 4.
REQ-002 SHALL provide parameter DEBOUNCE, default 8, consecutive identical full scans needed to accept a press or a release; minimum 1.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous active-low reset.
REQ-005 SHALL have port row  input  4  keypad row sense, active-low, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have ports dig1, dig2, dig3, dig4  output  4 each  entered hex digits; dig1 is the newest, dig4 the oldest.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse per accepted keypress.
REQ-009 SHALL have port key_code  output  4  hex code of the last accepted key, held until the next acceptance.
REQ-010 SHALL have port key_down  output  1  high while a debounced key is held.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer before any use.
REQ-012 SHALL drive columns in the fixed order col=1110, 1101, 1011, 0111, then wrap; each pattern is held for SCAN_DIV cycles.
REQ-013 SHALL sample the synchronized row on the last cycle of each column dwell only.
REQ-014 SHALL map (column i, row j, row 0 at top) to code: col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
REQ-015 SHALL classify each completed 4-column scan, ending at the col3 sample, as NONE (no row low), SINGLE(code) (exactly one row low in exactly one column) or MULTI (anything else).
REQ-016 SHALL run a debounce FSM with states IDLE, CAND, PRESSED and REL, advanced once per completed scan.
REQ-017 IDLE: on SINGLE(c), latch candidate c, set count=1 and go to CAND; otherwise stay in IDLE.
REQ-018 CAND: on SINGLE(same c), increment count; on NONE, MULTI or a different code, return to IDLE with count=0.
REQ-019 CAND: when count reaches DEBOUNCE, go to PRESSED and accept c; with DEBOUNCE=1, IDLE goes directly to PRESSED.
REQ-020 Accept SHALL do all of the following on one clock edge: pulse key_valid high for exactly one cycle, set key_code=c, and shift dig4<=dig3, dig3<=dig2, dig2<=dig1, dig1<=c.
REQ-021 PRESSED: on NONE, go to REL with count=1; on SINGLE (any code) or MULTI, stay in PRESSED; no autorepeat and no second accept.
REQ-022 REL: on NONE, increment count and go to IDLE when count reaches DEBOUNCE; on any key, return to PRESSED.
REQ-023 key_down SHALL be high in PRESSED and REL, and low in IDLE and CAND.
REQ-024 Accept latency SHALL be exactly one clk cycle after the col3 sample of the DEBOUNCE-th matching scan.
REQ-025 Dwell counter width SHALL be clog2(SCAN_DIV); the debounce count SHALL saturate at DEBOUNCE and never wrap.
REQ-026 A new code pressed without an intervening debounced release SHALL NOT be accepted.

Reset
REQ-027 While clr=0, the following SHALL hold immediately and asynchronously: col=1110, dig1..dig4=0, key_code=0, key_valid=0, key_down=0, FSM=IDLE, counters=0, synchronizer=1111.
REQ-028 Reset asserted mid-scan or mid-debounce SHALL discard all partial state; after release, scanning restarts at col0 with a full dwell.
REQ-029 Release of clr SHALL NOT cause a key_valid pulse.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-030 Reset, no key for 10 scans -> col rotates every 4 cycles; key_valid never pulses; dig1..dig4=0.
REQ-031 Hold key 5 (col1, row1) stable for 4 scans, then release for 3 scans -> exactly one key_valid pulse one cycle after the 2nd scan's col3 sample; dig1=5, others 0; key_code=5; key_down falls after the 2nd empty scan.
REQ-032 Enter 1,2,3,A,F with clean presses and releases -> dig4..dig1 = 2,3,A,F; 5 pulses total.
REQ-033 Key 7 present for 1 scan, absent for 1 scan, present for 1 scan -> no key_valid pulse; FSM returns to IDLE.
REQ-034 Hold key 4, then press key 8 as well (MULTI), then release 4 only -> one accept (4) and no accept for 8 until a full release.
REQ-035 Assert clr in CAND with one scan counted, release it, keep holding the key -> acceptance occurs only after 2 new full scans; all outputs are at reset values during clr.
